async_fifo_rd_ctrl: RTL
=======================

Name: async_fifo_rd_ctrl

Overview:
Read-side pointer and flag controller for the dual-clock FIFO; the counterpart of the write-side controller. It owns the read address into the shared dual-port RAM and accepts the write pointer from the write domain as Gray code. It synchronises that pointer into rd_clk, converts it to binary, and produces empty, programmable-empty, occupancy and a registered read-valid strobe. It also exports its own pointer in registered Gray code for the write domain.

Parameters:
RAM_ADDR_WIDTH, 8, pointer width including wrap bit; RAM depth = 2^(RAM_ADDR_WIDTH-1); low RAM_ADDR_WIDTH-1 bits address the RAM
SYNC_STAGES, 2, flop stages in the Gray-pointer synchroniser (legal 2..4)
PROG_EMPTY, 4, prog_empty asserted when occupancy <= this value (legal 0..2^(RAM_ADDR_WIDTH-1)-1)

Ports:
rd_clk  in  1  read-domain clock; the only clock of this block
rd_rst  in  1  synchronous active-high reset, sampled on rd_clk rising edge
rd_en  in  1  read request; accepted only when empty=0
wraddr_gray  in  RAM_ADDR_WIDTH  write pointer, Gray coded, driven from a write-domain register
rdaddr  out  RAM_ADDR_WIDTH  binary read pointer; low bits drive RAM read address
rdaddr_gray  out  RAM_ADDR_WIDTH  registered Gray code of rdaddr, for the write-domain synchroniser
empty  out  1  FIFO empty as seen by read domain
prog_empty  out  1  occupancy <= PROG_EMPTY
elements_rd  out  RAM_ADDR_WIDTH  occupancy seen by read domain, 0..2^(RAM_ADDR_WIDTH-1)
rd_valid  out  1  one-cycle strobe: RAM data for the accepted read is valid this cycle
underflow  out  1  one-cycle strobe: rd_en was asserted while empty=1 in the previous cycle

Behaviour:
- Reset on rd_clk edge with rd_rst=1: rdaddr=0, rdaddr_gray=0, all synchroniser stages=0, rd_valid=0, underflow=0. Resulting combinational outputs: empty=1, elements_rd=0, prog_empty=1. Reset has priority over rd_en.
- Synchroniser: SYNC_STAGES-deep flop chain on wraddr_gray. The last stage feeds a combinational gray-to-binary converter giving sync_wraddr. No other logic touches the chain.
- Accepted read: rd_en=1 and empty=0 at a rising edge -> rdaddr increments by 1, modulo 2^RAM_ADDR_WIDTH. The wrap bit toggles naturally when the low bits roll over.
- rd_en while empty=1 -> rdaddr holds, no rd_valid, underflow=1 on the next cycle.
- rdaddr_gray <= bin2gray(next rdaddr) in the same edge as the rdaddr update. It therefore always equals gray(rdaddr) with no extra lag.
- rd_valid <= rd_en & ~empty. This matches a RAM with 1-cycle registered read: data for address A is valid in the cycle after rdaddr=A was presented and accepted.
- empty = (rdaddr == sync_wraddr), full width including wrap bit. Combinational from registers only.
- elements_rd = sync_wraddr - rdaddr, RAM_ADDR_WIDTH-bit modulo subtraction. The maximum 2^(RAM_ADDR_WIDTH-1) is representable (MSB set, low bits 0).
- prog_empty = (elements_rd <= PROG_EMPTY), unsigned compare.
- Write-to-visibility latency: a write-pointer change registered in the write domain appears in sync_wraddr after SYNC_STAGES rd_clk edges (plus up to one edge of metastability resolution). empty/elements_rd are therefore pessimistic: they may under-report occupancy but never over-report it.
- Empty->non-empty: earliest accepted read is the cycle in which empty first reads 0. Back-to-back reads every cycle are supported until empty.
- Reading the last word: on the edge that makes rdaddr == sync_wraddr, empty rises in the same cycle rdaddr updates. A further rd_en is then rejected.
- Wrap-around: rdaddr passing 2^RAM_ADDR_WIDTH-1 -> 0 must leave empty/elements_rd correct; no special case is needed beyond modulo arithmetic.
- Mid-operation reset: any in-flight rd_valid is cleared on the reset edge. Write-domain reset must be applied concurrently by the system; this block does not detect a one-sided reset.
- wraddr_gray is assumed to change at most one bit per write-domain edge; no other CDC path exists.

Test Plan:
- Reset: W=4, hold rd_rst 3 cycles with wraddr_gray=0 -> rdaddr=0, rdaddr_gray=0, empty=1, prog_empty=1, elements_rd=0, rd_valid=0.
- Sync latency: W=4, SYNC_STAGES=2, step wraddr_gray 0->1 (one write) -> empty falls exactly 2 edges later. Then rd_en=1 for 1 cycle -> rdaddr=1, rd_valid=1 next cycle, empty=1.
- Fill and drain: drive wraddr_gray=gray(8) (full, 8 words) -> elements_rd=8 (4'b1000), prog_empty=0 (PROG_EMPTY=4). Read continuously -> prog_empty rises when elements_rd=4, empty after 8 reads, exactly 8 rd_valid pulses.
- Underflow: empty=1, rd_en=1 for 2 cycles -> rdaddr unchanged, rd_valid=0, underflow=1 for 2 cycles, each lagging rd_en by one cycle.
- Wrap: preload via 14 writes/reads to rdaddr=14, then wraddr_gray=gray(2) -> elements_rd=4. Read 4 words -> rdaddr sequence 15,0,1,2; empty=1 at rdaddr=2; rdaddr_gray=gray(rdaddr) every cycle.
- Reset mid-read: streaming reads with rd_valid=1, assert rd_rst one cycle (wraddr_gray forced 0) -> next cycle rdaddr=0, rd_valid=0, empty=1.

Source files
------------

// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side handshake bundle of the dual-clock FIFO.
// The slave modport is the controller; the master modport is the FIFO reader plus the write-domain pointer source.
interface async_fifo_rd_ctrl_if #(
  parameter int RAM_ADDR_WIDTH = 8
);
  logic                      rd_en;
  logic [RAM_ADDR_WIDTH-1:0] wraddr_gray;
  logic [RAM_ADDR_WIDTH-1:0] rdaddr;
  logic [RAM_ADDR_WIDTH-1:0] rdaddr_gray;
  logic                      empty;
  logic                      prog_empty;
  logic [RAM_ADDR_WIDTH-1:0] elements_rd;
  logic                      rd_valid;
  logic                      underflow;

  modport master (
    output rd_en, wraddr_gray,
    input  rdaddr, rdaddr_gray, empty, prog_empty, elements_rd, rd_valid, underflow
  );

  modport slave (
    input  rd_en, wraddr_gray,
    output rdaddr, rdaddr_gray, empty, prog_empty, elements_rd, rd_valid, underflow
  );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer/flag controller for the dual-clock FIFO.
// Synchronises the Gray write pointer into rd_clk and derives empty, occupancy and the read strobes.
module async_fifo_rd_ctrl #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int PROG_EMPTY     = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  async_fifo_rd_ctrl_if.slave  bus
);
  localparam int W = RAM_ADDR_WIDTH;
  localparam logic [W-1:0] PE_THR = W'(PROG_EMPTY);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0] r_rdaddr;
  logic [W-1:0] r_rdaddr_gray;
  logic         r_rd_valid;
  logic         r_underflow;

  logic [W-1:0] w_sync_wraddr;
  logic [W-1:0] w_elements;
  logic [W-1:0] w_rdaddr_nxt;
  logic         w_empty;
  logic         w_accept;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Pure flop chain: nothing else may sample the intermediate stages.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.wraddr_gray};
  end

  assign w_sync_wraddr = gray2bin(r_sync[SYNC_STAGES-1]);
  assign w_empty       = (r_rdaddr == w_sync_wraddr);
  assign w_elements    = w_sync_wraddr - r_rdaddr;
  assign w_accept      = bus.rd_en & ~w_empty;
  assign w_rdaddr_nxt  = w_accept ? r_rdaddr + 1'b1 : r_rdaddr;

  // Gray copy is taken from the next pointer so it never lags rdaddr.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_rdaddr      <= '0;
      r_rdaddr_gray <= '0;
      r_rd_valid    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_rdaddr      <= w_rdaddr_nxt;
      r_rdaddr_gray <= w_rdaddr_nxt ^ (w_rdaddr_nxt >> 1);
      r_rd_valid    <= w_accept;
      r_underflow   <= bus.rd_en & w_empty;
    end
  end

  assign bus.rdaddr      = r_rdaddr;
  assign bus.rdaddr_gray = r_rdaddr_gray;
  assign bus.empty       = w_empty;
  assign bus.elements_rd = w_elements;
  assign bus.prog_empty  = (w_elements <= PE_THR);
  assign bus.rd_valid    = r_rd_valid;
  assign bus.underflow   = r_underflow;
endmodule
